reg_commit_queue: RTL and testbench
===================================

// Module: reg_commit_queue
// PURPOSE
//  Commit-to-RegisterFile write sequencer. Buffers committed results {rd, value, rob_id} from the ReorderBuffer.
//  Drains them one per cycle onto the RegisterFile write port (set_reg_id / set_val / set_reg_on_rob_id).
//  Holds off writes on cycles when the RegisterFile ignores them (rob_clear, !rdy_in).
//  Forwards the youngest queued value for two lookup ids, so issue never reads a stale architectural value.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >= 2
//  ROB_W  4  ROB index width (matches `ROB_WIDTH_BIT)
//  CNT_W  3  occupancy width, = clog2(DEPTH+1)
// PORTS
//  clk_in             in   1      system clock
//  rst_in             in   1      reset, synchronous, active-low
//  rdy_in             in   1      global ready; low = freeze
//  rob_clear          in   1      ROB flush this cycle
//  commit_valid       in   1      ROB presents a committed result
//  commit_reg_id      in   5      destination register (0 = no write)
//  commit_val         in   32     result value
//  commit_rob_id      in   ROB_W  ROB entry of the result
//  commit_ready       out  1      queue can accept this cycle
//  set_reg_id         out  5      RF write reg id (0 = no write)
//  set_val            out  32     RF write value
//  set_reg_on_rob_id  out  ROB_W  RF write ROB tag
//  fwd_id1/fwd_id2    in   5      lookup register ids
//  fwd_hit1/fwd_hit2  out  1      lookup id is pending in queue
//  fwd_val1/fwd_val2  out  32     youngest pending value for that id
//  empty              out  1      no entries held
//  count              out  CNT_W  entries held
// BEHAVIOUR
//  State: DEPTH-entry circular buffer {reg_id, val, rob_id}, head/tail pointers mod DEPTH, count.
//   Reset: rst_in low at posedge -> head=tail=count=0; contents don't care.
//   While rst_in is low, commit_ready=0, set_reg_id=0, fwd_hit*=0.
//  Push fires when commit_valid && commit_ready && rdy_in && rst_in.
//  commit_ready = rst_in && rdy_in && (count < DEPTH); it does not depend on a same-cycle pop (no full bypass).
//  Accepted entries with commit_reg_id==0 are consumed but not stored; count is unchanged.
//  Drain enable: drain = rst_in && rdy_in && !rob_clear && !empty.
//   drain=1 -> set_* = head entry (combinational); head++ and count-- at posedge.
//   drain=0 -> set_reg_id=0, set_val=0, set_reg_on_rob_id=0.
//  Latency: an entry pushed at edge N is written to the RF at edge N+1 at the earliest. Strict FIFO order.
//  Simultaneous push+pop: count unchanged; tail and head both advance.
//  rob_clear: queue contents are preserved, because committed results are architectural. No drain that cycle.
//   Pushes are still accepted. Drain resumes the next cycle.
//  rdy_in low: pointers, count and contents frozen; set_reg_id=0.
//  Forwarding (combinational):
//   fwd_hitK = fwd_idK != 0 and some held entry (head..tail-1) has reg_id == fwd_idK.
//   The entry being drained this cycle counts as held.
//   fwd_valK = value of the youngest such entry (closest to tail); 0 when there is no hit.
//   A commit arriving in the same cycle is NOT visible to forwarding.
//  Wrap-around: pointers wrap DEPTH-1 -> 0. Full: count==DEPTH. Empty: count==0.
//   Youngest-match priority must hold across the wrap.
//  Mid-operation reset: queue is emptied; pending entries are discarded.
// TESTING
//  1 reset low 2 cycles, release -> empty=1, count=0, commit_ready=1, set_reg_id=0.
//  2 push {rd=5, 0x1234, rob 3} at edge N
//    -> cycle N+1: set_reg_id=5, set_val=0x1234, set_reg_on_rob_id=3; empty=1 after edge N+1.
//  3 hold rdy_in=1, drain blocked via rob_clear; push 4 entries -> commit_ready=0 at count=4.
//    5th commit is not accepted; after release, drain order = push order.
//  4 push rd=7 vals 0xA then 0xB with drain blocked by rob_clear; fwd_id1=7 -> fwd_hit1=1, fwd_val1=0xB.
//    fwd_id2=0 -> fwd_hit2=0.
//  5 rob_clear=1 with 2 entries queued -> set_reg_id=0, count stays 2.
//    Next cycle drains the head; a push in the clear cycle is retained.
//  6 push rd=0 -> commit_ready=1, count unchanged, no RF write.
//    Cycle 8+ entries through DEPTH=4 for pointer wrap -> FIFO order and forwarding stay correct.

Source files
------------

// File: rtl/reg_commit_queue.sv
// Commit-to-RegisterFile write sequencer: buffers committed {rd, value, rob_id}
// results and drains them in order, one per cycle, onto the RF write port.
// Latency: an entry pushed at edge N reaches set_* during the cycle before edge N+1.
// Backpressure: commit_ready drops when the queue is full or rdy_in is low.
// Draining pauses while rob_clear or !rdy_in.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global freeze), rob_clear (flush)
//   commit_valid/commit_reg_id/commit_val/commit_rob_id -> commit_ready
//   set_reg_id/set_val/set_reg_on_rob_id : RF write port (reg id 0 = no write)
//   fwd_id1/fwd_id2 -> fwd_hit1/fwd_hit2, fwd_val1/fwd_val2 : youngest pending value
//   empty, count : occupancy
module reg_commit_queue #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic             commit_valid,
  input  logic [4:0]       commit_reg_id,
  input  logic [31:0]      commit_val,
  input  logic [ROB_W-1:0] commit_rob_id,
  output logic             commit_ready,
  output logic [4:0]       set_reg_id,
  output logic [31:0]      set_val,
  output logic [ROB_W-1:0] set_reg_on_rob_id,
  input  logic [4:0]       fwd_id1,
  input  logic [4:0]       fwd_id2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_val1,
  output logic [31:0]      fwd_val2,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       reg_id_q [DEPTH];
  logic [31:0]      val_q    [DEPTH];
  logic [ROB_W-1:0] rob_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic drain;

  // Readiness ignores a same-cycle drain, so a full queue never accepts.
  assign commit_ready = rst_in && rdy_in && (count_q < CNT_W'(DEPTH));
  // rd==0 commits are accepted (handshake completes) but have nothing to write.
  assign push  = commit_valid && commit_ready && (commit_reg_id != 5'd0);
  assign drain = rst_in && rdy_in && !rob_clear && (count_q != '0);

  assign set_reg_id        = drain ? reg_id_q[head_q] : 5'd0;
  assign set_val           = drain ? val_q[head_q]    : 32'd0;
  assign set_reg_on_rob_id = drain ? rob_q[head_q]    : '0;

  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push)  tail_d = tail_q + 1'b1;
    if (drain) head_d = head_q + 1'b1;
    if (push && !drain)      count_d = count_q + 1'b1;
    else if (!push && drain) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only slots inside head..tail-1 are ever read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      reg_id_q[tail_q] <= commit_reg_id;
      val_q[tail_q]    <= commit_val;
      rob_q[tail_q]    <= commit_rob_id;
    end
  end

  // Walk held entries oldest to youngest; later matches overwrite earlier
  // ones so the youngest wins, and indexing from head keeps that true across
  // the pointer wrap. The slot being drained this cycle is still included.
  always_comb begin
    fwd_hit1 = 1'b0;
    fwd_val1 = 32'd0;
    fwd_hit2 = 1'b0;
    fwd_val2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_in && (i < int'(count_q))) begin
        if ((fwd_id1 != 5'd0) && (reg_id_q[head_q + PTR_W'(i)] == fwd_id1)) begin
          fwd_hit1 = 1'b1;
          fwd_val1 = val_q[head_q + PTR_W'(i)];
        end
        if ((fwd_id2 != 5'd0) && (reg_id_q[head_q + PTR_W'(i)] == fwd_id2)) begin
          fwd_hit2 = 1'b1;
          fwd_val2 = val_q[head_q + PTR_W'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_commit_queue.sv
// Directed vector bench for reg_commit_queue.
// Latency: each vector is one clock cycle; outputs are sampled before the edge.
// Backpressure: vectors drive rob_clear/rdy_in to exercise stalls and full.
module tb_reg_commit_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, commit_valid;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_id;
  logic        commit_ready;
  logic [4:0]  set_reg_id;
  logic [31:0] set_val;
  logic [3:0]  set_reg_on_rob_id;
  logic [4:0]  fwd_id1, fwd_id2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_val1, fwd_val2;
  logic        empty;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  reg_commit_queue #(.DEPTH(4), .ROB_W(4), .CNT_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
    .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .commit_ready(commit_ready), .set_reg_id(set_reg_id), .set_val(set_val),
    .set_reg_on_rob_id(set_reg_on_rob_id), .fwd_id1(fwd_id1), .fwd_id2(fwd_id2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_val1(fwd_val1),
    .fwd_val2(fwd_val2), .empty(empty), .count(count)
  );

  typedef struct {
    int rst, rdy, clr, cv, rd, val, rob, f1, f2;
    int e_rdy, e_sid, e_sval, e_srob, e_h1, e_v1, e_h2, e_v2, e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, rdy, clr, cv, rd, val, rob, f1, f2,
                     input int e_rdy, e_sid, e_sval, e_srob,
                     input int e_h1, e_v1, e_h2, e_v2, e_cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr; v.cv = cv;
    v.rd = rd; v.val = val; v.rob = rob; v.f1 = f1; v.f2 = f2;
    v.e_rdy = e_rdy; v.e_sid = e_sid; v.e_sval = e_sval; v.e_srob = e_srob;
    v.e_h1 = e_h1; v.e_v1 = e_v1; v.e_h2 = e_h2; v.e_v2 = e_v2; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int rst, rdy, clr, cv, rd, val, rob, f1, f2);
    rst_in        = (rst != 0);
    rdy_in        = (rdy != 0);
    rob_clear     = (clr != 0);
    commit_valid  = (cv != 0);
    commit_reg_id = 5'(rd);
    commit_val    = 32'(val);
    commit_rob_id = 4'(rob);
    fwd_id1       = 5'(f1);
    fwd_id2       = 5'(f2);
  endtask

  initial begin
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_in);

    // rst rdy clr cv  rd  val     rob  f1 f2 | rdy sid sval    srob h1 v1     h2 v2    cnt
    add(0,1,0,0,  0, 0,      0,   0, 0,   0,  0, 0,      0,   0, 0,     0, 0,     0); // held in reset
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // released
    add(1,1,0,1,  5, 'h1234, 3,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // push
    add(1,1,0,0,  0, 0,      0,   5, 0,   1,  5, 'h1234, 3,   1, 'h1234,0, 0,     1); // next-cycle write
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,1,1,  1, 'h11,   1,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // fill under clear
    add(1,1,1,1,  2, 'h22,   2,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     1);
    add(1,1,1,1,  3, 'h33,   3,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     2);
    add(1,1,1,1,  4, 'h44,   4,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     3);
    add(1,1,1,1,  9, 'h99,   9,   2, 4,   0,  0, 0,      0,   1, 'h22,  1, 'h44,  4); // full: rejected
    add(1,1,0,0,  0, 0,      0,   0, 0,   0,  1, 'h11,   1,   0, 0,     0, 0,     4);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  2, 'h22,   2,   0, 0,     0, 0,     3);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  3, 'h33,   3,   0, 0,     0, 0,     2);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  4, 'h44,   4,   0, 0,     0, 0,     1);
    add(1,1,1,1,  7, 'hA,    5,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // rd7 = A
    add(1,1,1,1,  7, 'hB,    6,   7, 0,   1,  0, 0,      0,   1, 'hA,   0, 0,     1); // B not yet visible
    add(1,1,1,0,  0, 0,      0,   7, 0,   1,  0, 0,      0,   1, 'hB,   0, 0,     2); // youngest wins
    add(1,1,1,1,  8, 'h88,   7,   8, 0,   1,  0, 0,      0,   0, 0,     0, 0,     2); // push during clear
    add(1,1,0,0,  0, 0,      0,   7, 8,   1,  7, 'hA,    5,   1, 'hB,   1, 'h88,  3);
    add(1,1,0,0,  0, 0,      0,   7, 0,   1,  7, 'hB,    6,   1, 'hB,   0, 0,     2);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  8, 'h88,   7,   0, 0,     0, 0,     1);
    add(1,1,0,1,  0, 'hDEAD, 1,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // rd0 consumed
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,0,1,  9, 'h99,   2,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,0,0,1, 10, 'hAA,   3,   9, 0,   0,  0, 0,      0,   1, 'h99,  0, 0,     1); // frozen
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  9, 'h99,   2,   0, 0,     0, 0,     1);
    add(1,1,0,1, 11, 'hB1,   4,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,0,1, 12, 'hB2,   5,   0, 0,   1, 11, 'hB1,   4,   0, 0,     0, 0,     1); // push+pop
    add(1,1,0,0,  0, 0,      0,   0, 0,   1, 12, 'hB2,   5,   0, 0,     0, 0,     1);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,1,1, 13, 'hC1,   6,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,1,1, 14, 'hC2,   7,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     1);
    add(0,1,0,1, 15, 'hC3,   8,  13, 0,   0,  0, 0,      0,   0, 0,     0, 0,     2); // mid-op reset
    add(1,1,0,0,  0, 0,      0,  13, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);
    add(1,1,1,1, 20, 1,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0); // wrap run
    add(1,1,1,1, 21, 2,      1,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     1);
    add(1,1,1,1, 20, 3,      2,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     2);
    add(1,1,0,1, 21, 4,      3,  20,21,   1, 20, 1,      0,   1, 3,     1, 2,     3);
    add(1,1,0,1, 20, 5,      4,  20,21,   1, 21, 2,      1,   1, 3,     1, 4,     3);
    add(1,1,1,0,  0, 0,      0,  20,21,   1,  0, 0,      0,   1, 5,     1, 4,     3); // youngest across wrap
    add(1,1,0,0,  0, 0,      0,  20, 0,   1, 20, 3,      2,   1, 5,     0, 0,     3);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1, 21, 4,      3,   0, 0,     0, 0,     2);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1, 20, 5,      4,   0, 0,     0, 0,     1);
    add(1,1,0,0,  0, 0,      0,   0, 0,   1,  0, 0,      0,   0, 0,     0, 0,     0);

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      @(negedge clk_in);
      drive(v.rst, v.rdy, v.clr, v.cv, v.rd, v.val, v.rob, v.f1, v.f2);
      #1;
      chk($sformatf("v%0d commit_ready", k), 32'(commit_ready),      32'(v.e_rdy));
      chk($sformatf("v%0d set_reg_id", k),   32'(set_reg_id),        32'(v.e_sid));
      chk($sformatf("v%0d set_val", k),      set_val,                32'(v.e_sval));
      chk($sformatf("v%0d set_rob", k),      32'(set_reg_on_rob_id), 32'(v.e_srob));
      chk($sformatf("v%0d fwd_hit1", k),     32'(fwd_hit1),          32'(v.e_h1));
      chk($sformatf("v%0d fwd_val1", k),     fwd_val1,               32'(v.e_v1));
      chk($sformatf("v%0d fwd_hit2", k),     32'(fwd_hit2),          32'(v.e_h2));
      chk($sformatf("v%0d fwd_val2", k),     fwd_val2,               32'(v.e_v2));
      chk($sformatf("v%0d empty", k),        32'(empty),             32'(v.e_cnt == 0));
      chk($sformatf("v%0d count", k),        32'(count),             32'(v.e_cnt));
    end

    // Two fill/drain rounds of four entries each: eight entries through a
    // depth-4 ring, so both pointers wrap; drain order must match push order.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        int k;
        k = r * 4 + j;
        @(negedge clk_in);
        drive(1, 1, 1, 1, k + 1, 'hF000_0000 + k * 17, k, 0, 0);
      end
      @(negedge clk_in);
      drive(1, 1, 1, 1, 30, 'h5555, 15, r * 4 + 2, 0);
      #1;
      chk($sformatf("r%0d full ready", r), 32'(commit_ready), 32'd0);
      chk($sformatf("r%0d full count", r), 32'(count), 32'd4);
      chk($sformatf("r%0d fwd mid", r), fwd_val1, 32'('hF000_0000 + (r * 4 + 1) * 17));
      for (int j = 0; j < 4; j++) begin
        int k;
        k = r * 4 + j;
        @(negedge clk_in);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk($sformatf("r%0d drain%0d id", r, j),  32'(set_reg_id), 32'(k + 1));
        chk($sformatf("r%0d drain%0d val", r, j), set_val, 32'('hF000_0000 + k * 17));
        chk($sformatf("r%0d drain%0d rob", r, j), 32'(set_reg_on_rob_id), 32'(k % 16));
      end
      @(negedge clk_in);
      #1;
      chk($sformatf("r%0d empty after", r), 32'(empty), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
